// File: rtl/pwr8_arb_pkg.sv
// Shared constants, tag width helper and result entry type for the power-of-8 arbiter.
package pwr8_arb_pkg;

  localparam int PIPE_LAT  = 3;
  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 8 * IN_W_DEF;
  localparam int MAX_TAG_W = 3;

  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MAX_TAG_W-1:0] tag;
    logic [OUT_W_DEF-1:0] data;
  } res_entry_t;

endpackage

// File: rtl/pwr8_tag_pipe.sv
// Free-running x -> x^2 -> x^4 -> x^8 pipeline with a valid/tag shift register alongside.
module pwr8_tag_pipe
  import pwr8_arb_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int TAG_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [IN_W-1:0]   i_data,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [8*IN_W-1:0] o_data
);

  logic [PIPE_LAT-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q [PIPE_LAT];
  logic [2*IN_W-1:0]   sq1_d, sq1_q;
  logic [4*IN_W-1:0]   sq2_d, sq2_q;
  logic [8*IN_W-1:0]   sq3_d, sq3_q;

  // Operands are zero-extended first so every product is exact at full width.
  always_comb begin
    sq1_d = {{IN_W{1'b0}}, i_data} * {{IN_W{1'b0}}, i_data};
    sq2_d = {{(2*IN_W){1'b0}}, sq1_q} * {{(2*IN_W){1'b0}}, sq1_q};
    sq3_d = {{(4*IN_W){1'b0}}, sq2_q} * {{(4*IN_W){1'b0}}, sq2_q};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q <= '0;
      for (int k = 0; k < PIPE_LAT; k++) tag_q[k] <= '0;
      sq1_q <= '0;
      sq2_q <= '0;
      sq3_q <= '0;
    end else begin
      valid_q  <= {valid_q[PIPE_LAT-2:0], i_valid};
      tag_q[0] <= i_tag;
      for (int k = 1; k < PIPE_LAT; k++) tag_q[k] <= tag_q[k-1];
      sq1_q <= sq1_d;
      sq2_q <= sq2_d;
      sq3_q <= sq3_d;
    end
  end

  assign o_valid = valid_q[PIPE_LAT-1];
  assign o_tag   = tag_q[PIPE_LAT-1];
  assign o_data  = sq3_q;

endmodule

// File: rtl/pwr8_rr_arbiter.sv
// Round-robin front end sharing one x^8 pipeline, with credit-guarded FWFT result FIFO.
// Optional performance counters are built when PWR8_ARB_PERF_EN is defined.
module pwr8_rr_arbiter
  import pwr8_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  IN_W       = IN_W_DEF,
  parameter int  FIFO_DEPTH = 4,
  localparam int TAG_W      = tag_width(NUM_REQ),
  localparam int OUT_W      = 8 * IN_W
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*IN_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic                    o_res_valid,
  output logic [OUT_W-1:0]        o_res_data,
  output logic [TAG_W-1:0]        o_res_tag,
  input  logic                    i_res_ready,
`ifdef PWR8_ARB_PERF_EN
  output logic [NUM_REQ*32-1:0]   o_grant_cnt,
  output logic [31:0]             o_stall_cnt,
`endif
  output logic                    o_busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [OUT_W-1:0] data;
  } entry_t;

  logic               run_q;
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  entry_t             mem_q [FIFO_DEPTH];

  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic               found, credit_ok, issue, push, pop;
  logic [IN_W-1:0]    issue_data;
  logic               pipe_valid;
  logic [TAG_W-1:0]   pipe_tag;
  logic [OUT_W-1:0]   pipe_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    int j;
    j         = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && i_req_valid[TAG_W'(j)]) begin
        found     = 1'b1;
        grant_idx = TAG_W'(j);
      end
    end
    // Credit covers in-flight plus stored results, so a grant can never overflow the FIFO.
    credit_ok  = run_q && (credit_q < CNT_W'(FIFO_DEPTH));
    issue      = found && credit_ok;
    grant      = '0;
    if (issue) grant[grant_idx] = 1'b1;
    issue_data = i_req_data[grant_idx*IN_W +: IN_W];
    rr_ptr_d   = rr_ptr_q;
    if (issue) rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign push = pipe_valid;
  assign pop  = o_res_valid && i_res_ready;

  always_comb begin
    credit_d = credit_q;
    if (issue && !pop) credit_d = credit_q + 1'b1;
    else if (!issue && pop) credit_d = credit_q - 1'b1;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  pwr8_tag_pipe #(
    .IN_W  (IN_W),
    .TAG_W (TAG_W)
  ) u_pipe (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (issue),
    .i_tag     (grant_idx),
    .i_data    (issue_data),
    .o_valid   (pipe_valid),
    .o_tag     (pipe_tag),
    .o_data    (pipe_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      run_q      <= 1'b0;
      rr_ptr_q   <= '0;
      credit_q   <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      run_q      <= 1'b1;
      rr_ptr_q   <= rr_ptr_d;
      credit_q   <= credit_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {pipe_tag, pipe_data};
    end
  end

  assign o_req_ready = grant;
  assign o_res_valid = (fifo_cnt_q != '0);
  assign o_res_data  = o_res_valid ? mem_q[rd_ptr_q].data : '0;
  assign o_res_tag   = o_res_valid ? mem_q[rd_ptr_q].tag : '0;
  assign o_busy      = (credit_q != '0);

`ifdef PWR8_ARB_PERF_EN
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall = (|i_req_valid) && (credit_q == CNT_W'(FIFO_DEPTH));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    logic [31:0] grant_cnt_q;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) grant_cnt_q <= '0;
      else if (grant[gi] && (grant_cnt_q != '1)) grant_cnt_q <= grant_cnt_q + 1'b1;
    end
    assign o_grant_cnt[gi*32 +: 32] = grant_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
